// File: rtl/nested_param_pkg.sv
// Shared types and constants for the nested-parameter sampler slice.
package nested_param_pkg;

  typedef logic [1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam sample_t DEFAULT_EXP = ~2'b01;

endpackage

// File: rtl/nested_param_shreg.sv
// Frame shift register: newest sample enters the LSBs; clr and reset load
// every lane with RST_VAL.
module nested_param_shreg #(
  parameter int             W       = 2,
  parameter int             DEPTH   = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic [W-1:0]         din,
  output logic [DEPTH*W-1:0]   q
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= {DEPTH{RST_VAL}};
    end else if (shift_en) begin
      q <= {q[(DEPTH-1)*W-1:0], din};
    end
  end

endmodule

// File: rtl/nested_param_sampler.sv
// Frame sampler: captures DEPTH samples over valid/ready and counts mismatches
// against EXP. Optional NESTED_PARAM_EARLY_ABORT_EN ends a frame on its first mismatch.
//
// state   | meaning
// IDLE    | waiting for start; results of the last frame held
// CAPTURE | accepting samples (busy, in_ready)
// DONE    | one-cycle done pulse, match valid
module nested_param_sampler
  import nested_param_pkg::*;
#(
  parameter int           W     = 2,
  parameter int           DEPTH = 4,
  parameter int           CNT_W = 4,
  parameter logic [W-1:0] EXP   = DEFAULT_EXP,
  parameter logic [W-1:0] INIT  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [DEPTH*W-1:0] frame_out
);

  localparam int SC_W = $clog2(DEPTH + 1);

  state_t            state, state_nx;
  logic [SC_W-1:0]   scnt;
  logic [CNT_W-1:0]  mcnt;
  logic [CNT_W-1:0]  mcnt_inc;
  logic              match_q;
  logic              accept, is_miss, last, abort_hit, frame_clr, frame_end;

  assign accept    = in_valid & in_ready;
  assign is_miss   = accept && (in_data != EXP);
  assign mcnt_inc  = (is_miss && (mcnt != '1)) ? mcnt + 1'b1 : mcnt;
  assign last      = accept && (scnt == SC_W'(DEPTH - 1));
  assign frame_clr = (state == IDLE) && start;
`ifdef NESTED_PARAM_EARLY_ABORT_EN
  assign abort_hit = is_miss;
`else
  assign abort_hit = 1'b0;
`endif
  assign frame_end = last | abort_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      scnt    <= '0;
      mcnt    <= '0;
      match_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (frame_clr) begin
        scnt    <= '0;
        mcnt    <= '0;
        match_q <= 1'b0;
      end else if (accept) begin
        scnt <= scnt + 1'b1;
        mcnt <= mcnt_inc;
        // match is registered on the final accept so it is valid alongside done
        if (frame_end) match_q <= (mcnt_inc == '0);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CAPTURE;
      CAPTURE: if (frame_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state)
      CAPTURE: begin
        busy     = 1'b1;
        in_ready = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign match        = match_q;
  assign mismatch_cnt = mcnt;

  nested_param_shreg #(
    .W       (W),
    .DEPTH   (DEPTH),
    .RST_VAL (~INIT)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (frame_clr),
    .shift_en (accept),
    .din      (in_data),
    .q        (frame_out)
  );

endmodule

// File: tb/tb_nested_param_sampler.sv
// Scoreboard bench for nested_param_sampler; a second instance covers the
// small-counter saturation case. Expectations follow NESTED_PARAM_EARLY_ABORT_EN.
module tb_nested_param_sampler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, in_valid = 1'b0;
  logic [1:0] in_data = 2'b00;
  logic       in_ready, busy, done, match;
  logic [3:0] mismatch_cnt;
  logic [7:0] frame_out;

  logic        start2 = 1'b0, in_valid2 = 1'b0;
  logic [1:0]  in_data2 = 2'b00;
  logic        in_ready2, busy2, done2, match2;
  logic [1:0]  cnt2;
  logic [11:0] frame2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] frame;
    logic [3:0] cnt;
    logic       match;
    int         n;
  } exp_t;

  exp_t       sb[$];
  exp_t       last_e;
  logic [1:0] samp[8];

  always #5 clk = ~clk;

  nested_param_sampler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .busy(busy), .done(done),
    .match(match), .mismatch_cnt(mismatch_cnt), .frame_out(frame_out)
  );

  nested_param_sampler #(.CNT_W(2), .DEPTH(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_data(in_data2), .busy(busy2), .done(done2),
    .match(match2), .mismatch_cnt(cnt2), .frame_out(frame2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: what a 4-deep, 4-bit-count sampler with EXP=2'b10 reports.
  task automatic model_push();
    exp_t e;
    e.frame = 8'hFF;
    e.cnt   = 4'd0;
    e.n     = 0;
    for (int i = 0; i < 4; i++) begin
      e.frame = {e.frame[5:0], samp[i]};
      e.n++;
      if (samp[i] != 2'b10) begin
        if (e.cnt != 4'hF) e.cnt = e.cnt + 4'd1;
`ifdef NESTED_PARAM_EARLY_ABORT_EN
        break;
`endif
      end
    end
    e.match = (e.cnt == 4'd0);
    sb.push_back(e);
  endtask

  // Runs one frame; returns in the done cycle. vmask bit k gives in_valid on cycle k.
  task automatic run_frame(input string tag, input logic [15:0] vmask, input int nv,
                           input bit mid_start);
    exp_t e;
    int   need, acc, cyc, w;
    bit   v;
    model_push();
    need = sb[$].n;
    acc  = 0;
    cyc  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_start: busy=%b in_ready=%b required 1/1", tag, busy, in_ready);
    end
    while (acc < need && cyc < 40) begin
      v = (cyc < nv) ? vmask[cyc] : 1'b1;
      in_valid = v;
      in_data  = v ? samp[acc] : 2'b01;
      start    = mid_start && !v;
      tick();
      if (v) acc++;
      cyc++;
      if (acc < need) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
          failures++;
          $display("FAIL %s capture_flags: busy=%b done=%b in_ready=%b required 1/0/1",
                   tag, busy, done, in_ready);
        end
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = 2'b00;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s done_latency: done=%b required 1 one cycle after accept %0d",
               tag, done, need);
      w = 0;
      while (done !== 1'b1 && w < 8) begin
        tick();
        w++;
      end
      if (done !== 1'b1) $display("FAIL %s done_timeout: no done within bound", tag);
    end
    e = sb.pop_front();
    last_e = e;
    checks++;
    if (frame_out !== e.frame || mismatch_cnt !== e.cnt || match !== e.match) begin
      failures++;
      $display("FAIL %s result: frame=%h cnt=%0d match=%b required frame=%h cnt=%0d match=%b",
               tag, frame_out, mismatch_cnt, match, e.frame, e.cnt, e.match);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s done_flags: busy=%b in_ready=%b required 0/0", tag, busy, in_ready);
    end
  endtask

  // Leaves DONE, then checks results hold while junk is presented in IDLE.
  task automatic finish_frame(input string tag);
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse_width: done=%b busy=%b required 0/0", tag, done, busy);
    end
    in_valid = 1'b1;
    in_data  = 2'b01;
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (frame_out !== last_e.frame || mismatch_cnt !== last_e.cnt || match !== last_e.match) begin
      failures++;
      $display("FAIL %s hold: frame=%h cnt=%0d match=%b required frame=%h cnt=%0d match=%b",
               tag, frame_out, mismatch_cnt, match, last_e.frame, last_e.cnt, last_e.match);
    end
  endtask

  task automatic set_samp(input logic [1:0] a, b, c, d);
    samp[0] = a; samp[1] = b; samp[2] = c; samp[3] = d;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || match !== 1'b0 || mismatch_cnt !== 4'd0 ||
        frame_out !== 8'hFF || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b match=%b cnt=%0d frame=%h rdy=%b required 0/0/0/0/ff/0",
               busy, done, match, mismatch_cnt, frame_out, in_ready);
    end
  endtask

  task automatic test_match();
    set_samp(2'b10, 2'b10, 2'b10, 2'b10);
    run_frame("match", 16'h0, 0, 1'b0);
    finish_frame("match");
  endtask

  task automatic test_mismatch();
    set_samp(2'b10, 2'b01, 2'b10, 2'b00);
    run_frame("mismatch", 16'h0, 0, 1'b0);
    finish_frame("mismatch");
  endtask

  task automatic test_gaps();
    set_samp(2'b10, 2'b10, 2'b10, 2'b10);
    run_frame("gaps", 16'b1011001, 7, 1'b1);
    finish_frame("gaps");
  endtask

  task automatic test_early_abort();
    set_samp(2'b10, 2'b00, 2'b10, 2'b10);
    run_frame("abort", 16'h0, 0, 1'b0);
    finish_frame("abort");
  endtask

  task automatic test_start_in_done();
    set_samp(2'b11, 2'b10, 2'b10, 2'b10);
    run_frame("start_done", 16'h0, 0, 1'b0);
    start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || frame_out !== last_e.frame) begin
      failures++;
      $display("FAIL start_done ignored: busy=%b frame=%h required 0/%h", busy, frame_out, last_e.frame);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mismatch_cnt !== 4'd0 || frame_out !== 8'hFF || match !== 1'b0) begin
      failures++;
      $display("FAIL start_idle honoured: busy=%b cnt=%0d frame=%h match=%b required 1/0/ff/0",
               busy, mismatch_cnt, frame_out, match);
    end
    do_reset();
  endtask

  task automatic test_saturate();
    int         need;
    logic [1:0] ecnt;
    logic [11:0] eframe;
`ifdef NESTED_PARAM_EARLY_ABORT_EN
    need = 1; ecnt = 2'd1; eframe = 12'hFFC;
`else
    need = 6; ecnt = 2'd3; eframe = 12'h000;
`endif
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < need; i++) begin
      in_valid2 = 1'b1;
      in_data2  = 2'b00;
      tick();
    end
    in_valid2 = 1'b0;
    checks++;
    if (done2 !== 1'b1) begin
      failures++;
      $display("FAIL saturate done: done=%b required 1 after accept %0d", done2, need);
    end
    checks++;
    if (cnt2 !== ecnt || match2 !== 1'b0 || frame2 !== eframe) begin
      failures++;
      $display("FAIL saturate result: cnt=%0d match=%b frame=%h required %0d/0/%h",
               cnt2, match2, frame2, ecnt, eframe);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 2'b10;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || frame_out !== 8'hFF || mismatch_cnt !== 4'd0 ||
        in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b frame=%h cnt=%0d rdy=%b required 0/0/ff/0/0",
               busy, done, frame_out, mismatch_cnt, in_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL reset_mid activity: %0d cycles of done/busy required 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_gaps();
    test_early_abort();
    test_start_in_done();
    test_saturate();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
